// File: rtl/sr_bist.sv
// sr_bist: self-test engine for the serial shift register.
// It first measures the latency with a single marker bit, then sends PRBS7 data
// and counts received-bit mismatches.
module sr_bist #(
   parameter int unsigned MAX_LAT  = 200,
   parameter int unsigned PRBS_LEN = 1024,
   parameter int unsigned ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_strobe,
   input  logic             start,
   input  logic             sr_out_i,
   output logic             sr_in_o,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [7:0]       latency,
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned LAT_W = 8;
   localparam int unsigned CMP_W = $clog2(PRBS_LEN + 1);
   localparam logic [6:0]  SEED  = 7'h7F;

   typedef enum logic [2:0] {
      S_IDLE, S_FLUSH, S_MARK, S_WAIT, S_PRBS, S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [LAT_W-1:0] cnt, cnt_nxt;
   logic [LAT_W-1:0] cnt_inc_c;
   logic [LAT_W-1:0] skip, skip_nxt;
   logic [CMP_W-1:0] cmp, cmp_nxt;
   logic [6:0]       tx_lfsr, tx_nxt;
   logic [6:0]       rx_lfsr, rx_nxt;
   logic             tx_bit_c, rx_bit_c;
   logic             sr_in_nxt, busy_nxt, done_nxt, fail_nxt;
   logic [7:0]       latency_nxt;
   logic [ERR_W-1:0] err_nxt;

   // PRBS7 (x^7 + x^6 + 1): the feedback bit is also the emitted bit
   assign tx_bit_c  = tx_lfsr[6] ^ tx_lfsr[5];
   assign rx_bit_c  = rx_lfsr[6] ^ rx_lfsr[5];
   assign cnt_inc_c = cnt + LAT_W'(1);

   // State, counters, LFSRs and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         skip      <= '0;
         cmp       <= '0;
         tx_lfsr   <= '0;
         rx_lfsr   <= '0;
         sr_in_o   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         latency   <= '0;
         err_count <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         skip      <= skip_nxt;
         cmp       <= cmp_nxt;
         tx_lfsr   <= tx_nxt;
         rx_lfsr   <= rx_nxt;
         sr_in_o   <= sr_in_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         fail      <= fail_nxt;
         latency   <= latency_nxt;
         err_count <= err_nxt;
      end
   end

   // Next-state and next-output logic; all launch/sample work is strobe-qualified
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      skip_nxt    = skip;
      cmp_nxt     = cmp;
      tx_nxt      = tx_lfsr;
      rx_nxt      = rx_lfsr;
      sr_in_nxt   = sr_in_o;
      busy_nxt    = busy;
      done_nxt    = done;
      fail_nxt    = fail;
      latency_nxt = latency;
      err_nxt     = err_count;

      case (state)
         S_IDLE, S_DONE: begin
            sr_in_nxt = 1'b0;
            if (start) begin
               latency_nxt = '0;
               err_nxt     = '0;
               done_nxt    = 1'b0;
               fail_nxt    = 1'b0;
               busy_nxt    = 1'b1;
               cnt_nxt     = '0;
               tx_nxt      = SEED;
               rx_nxt      = SEED;
               state_nxt   = S_FLUSH;
            end
         end

         S_FLUSH: begin
            sr_in_nxt = 1'b0;
            if (bit_strobe) begin
               if (cnt == LAT_W'(MAX_LAT - 1)) begin
                  cnt_nxt   = '0;
                  state_nxt = S_MARK;
               end else begin
                  cnt_nxt = cnt_inc_c;
               end
            end
         end

         S_MARK: begin
            if (bit_strobe) begin
               sr_in_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_WAIT;
            end
         end

         S_WAIT: begin
            if (bit_strobe) begin
               if (sr_out_i) begin
                  // Marker seen: this strobe also launches the first PRBS bit
                  latency_nxt = cnt_inc_c;
                  skip_nxt    = cnt;
                  cmp_nxt     = '0;
                  sr_in_nxt   = tx_bit_c;
                  tx_nxt      = {tx_lfsr[5:0], tx_bit_c};
                  state_nxt   = S_PRBS;
               end else if (cnt_inc_c == LAT_W'(MAX_LAT)) begin
                  latency_nxt = LAT_W'(MAX_LAT);
                  fail_nxt    = 1'b1;
                  busy_nxt    = 1'b0;
                  done_nxt    = 1'b1;
                  sr_in_nxt   = 1'b0;
                  state_nxt   = S_DONE;
               end else begin
                  sr_in_nxt = 1'b0;
                  cnt_nxt   = cnt_inc_c;
               end
            end
         end

         S_PRBS: begin
            if (bit_strobe) begin
               sr_in_nxt = tx_bit_c;
               tx_nxt    = {tx_lfsr[5:0], tx_bit_c};
               if (skip != '0) begin
                  // First PRBS bit has not reached the output yet
                  skip_nxt = skip - LAT_W'(1);
               end else begin
                  rx_nxt = {rx_lfsr[5:0], rx_bit_c};
                  if ((sr_out_i != rx_bit_c) && (err_count != '1)) begin
                     err_nxt = err_count + ERR_W'(1);
                  end
                  if (cmp == CMP_W'(PRBS_LEN - 1)) begin
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                     fail_nxt  = 1'b0;
                     sr_in_nxt = 1'b0;
                     state_nxt = S_DONE;
                  end else begin
                     cmp_nxt = cmp + CMP_W'(1);
                  end
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sr_bist.sv
// tb_sr_bist: directed bench for sr_bist with a loopback or a 64-stage delay model.
module tb_sr_bist;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bit_strobe = 1'b0;
   logic        start = 1'b0;
   logic        sr_out_i;
   logic        sr_in_o, busy, done, fail;
   logic [7:0]  latency;
   logic [15:0] err_count;

   int          checks = 0;
   int          errors = 0;
   int          mode = 0;        // 0: stuck at 0, 1: direct wire, 2: 64-stage delay
   int          flip_mode = 0;   // 0: none, 1: bits 10/500/1023, 2: every compared bit
   int          scnt = 0;        // strobes since the last armed start
   int          div = 0;
   bit          rearm = 1'b0;
   logic        flip;
   logic [63:0] chain = '0;

   always #5 clk = ~clk;

   sr_bist dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_strobe (bit_strobe),
      .start      (start),
      .sr_out_i   (sr_out_i),
      .sr_in_o    (sr_in_o),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .latency    (latency),
      .err_count  (err_count)
   );

   // One strobe every 4 clk
   initial begin
      forever begin
         @(negedge clk);
         bit_strobe = (div == 3);
         div = (div + 1) % 4;
      end
   end

   // Strobe-advanced delay line and strobe counter
   always @(posedge clk) begin
      if (bit_strobe) chain <= {chain[62:0], sr_in_o};
      if (start && rearm) scnt <= 0;
      else if (bit_strobe) scnt <= scnt + 1;
   end

   // Received-bit model; compare k of a latency-65 run is on strobe 331+k
   always_comb begin
      flip = 1'b0;
      if (flip_mode == 1) flip = (scnt == 340) || (scnt == 830) || (scnt == 1353);
      else if (flip_mode == 2) flip = (scnt >= 330) && (scnt <= 1353);
      case (mode)
         1:       sr_out_i = sr_in_o;
         2:       sr_out_i = chain[63] ^ flip;
         default: sr_out_i = 1'b0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input bit with_strobe, input bit arm);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         if (bit_strobe == with_strobe) break;
      end
      rearm = arm;
      start = 1'b1;
      @(negedge clk);
      #1;
      start = 1'b0;
      rearm = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic prev_busy;
      bit   got;
      got = 1'b0;
      prev_busy = busy;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         #2;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
         prev_busy = busy;
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      check({tag, "_busy_before_done"}, 32'(prev_busy), 32'd1);
   endtask

   task automatic wait_scnt(input int target);
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         #2;
         if (scnt >= target) break;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_sr_in"}, 32'(sr_in_o), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_fail"}, 32'(fail), 32'd0);
      check({tag, "_latency"}, 32'(latency), 32'd0);
      check({tag, "_err"}, 32'(err_count), 32'd0);
   endtask

   task automatic check_result(input string tag, input int f, input int lat,
                               input int err, input int len);
      check({tag, "_fail"}, 32'(fail), 32'(f));
      check({tag, "_latency"}, 32'(latency), 32'(lat));
      check({tag, "_err"}, 32'(err_count), 32'(err));
      check({tag, "_strobes"}, 32'(scnt), 32'(len));
   endtask

   // Directed sequence
   initial begin
      repeat (3) @(negedge clk);
      #2;
      check_zero("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Direct loopback: 200 + 1 + 1 + 1 + 1023 strobes
      mode = 1;
      pulse_start(1'b0, 1'b1);
      wait_done("direct");
      check_result("direct", 0, 1, 0, 1226);

      // 64-stage delay: 200 + 1 + 65 + 65 + 1023 strobes
      mode = 2;
      pulse_start(1'b0, 1'b1);
      wait_done("delay64");
      check_result("delay64", 0, 65, 0, 1354);

      // Repeat without reset; done must drop on start
      pulse_start(1'b0, 1'b1);
      check("rerun_done_drop", 32'(done), 32'd0);
      check("rerun_busy_rise", 32'(busy), 32'd1);
      wait_done("rerun");
      check_result("rerun", 0, 65, 0, 1354);

      // Stuck-at-0 output: timeout after 200 + 1 + 200 strobes
      mode = 0;
      pulse_start(1'b0, 1'b1);
      wait_done("stuck");
      check_result("stuck", 1, 200, 0, 401);

      // Three corrupted received bits
      mode = 2;
      flip_mode = 1;
      pulse_start(1'b0, 1'b1);
      wait_done("inv3");
      check_result("inv3", 0, 65, 3, 1354);

      // Every received bit corrupted
      flip_mode = 2;
      pulse_start(1'b0, 1'b1);
      wait_done("invall");
      check_result("invall", 0, 65, 1024, 1354);
      flip_mode = 0;

      // Asynchronous reset in the middle of PRBS
      pulse_start(1'b0, 1'b1);
      wait_scnt(600);
      check("mid_prbs_busy", 32'(busy), 32'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_start(1'b0, 1'b1);
      wait_done("post_rst");
      check_result("post_rst", 0, 65, 0, 1354);

      // start while busy in FLUSH, WAIT and PRBS is ignored
      pulse_start(1'b0, 1'b1);
      wait_scnt(50);
      pulse_start(1'b0, 1'b0);
      wait_scnt(230);
      pulse_start(1'b0, 1'b0);
      wait_scnt(600);
      pulse_start(1'b0, 1'b0);
      check("ignored_still_busy", 32'(busy), 32'd1);
      wait_done("ignore");
      check_result("ignore", 0, 65, 0, 1354);

      // start on a strobe cycle in IDLE: marker goes out on the 201st later strobe
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulse_start(1'b1, 1'b1);
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         #2;
         if (sr_in_o === 1'b1) break;
      end
      check("coincident_mark_strobe", 32'(scnt), 32'd201);
      wait_done("coincident");
      check_result("coincident", 0, 65, 0, 1354);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
